// File: rtl/four_bit_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM state encoding.
package four_bit_serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/four_bit_serial_subtractor_full_subtractor.sv
// One-bit full subtractor: difference and borrow for a single bit position.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BIN,
  output logic D,
  output logic BOUT
);

  assign D    = A ^ B ^ BIN;
  assign BOUT = (~A & B) | (~(A ^ B) & BIN);

endmodule

// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: captures A/B, walks one bit per cycle LSB-first,
// then holds DIFF/BOUT until the consumer takes the result.
module four_bit_serial_subtractor
  import four_bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT
);

  localparam int               IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic [IDX_W-1:0] idx;
  logic             borrow;
  logic             bit_d;
  logic             bit_bout;

  full_subtractor u_fs (
    .A    (a_reg[idx]),
    .B    (b_reg[idx]),
    .BIN  (borrow),
    .D    (bit_d),
    .BOUT (bit_bout)
  );

  // Partial difference accumulates here so DIFF only changes when a result completes.
  always_comb begin
    work_next      = work;
    work_next[idx] = bit_d;
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      work   <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      DIFF   <= '0;
      BOUT   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg  <= A;
            b_reg  <= B;
            borrow <= 1'b0;
            idx    <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          work   <= work_next;
          borrow <= bit_bout;
          if (idx == LAST_IDX) begin
            DIFF  <= work_next;
            BOUT  <= bit_bout;
            state <= ST_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_four_bit_serial_subtractor.sv
// Self-checking bench for the bit-serial subtractor: vector table, corner sequences, stream and sweep.
module tb_four_bit_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] DIFF;
  logic             BOUT;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] diff;
    logic       bout;
  } vec_t;

  vec_t vecs [8];

  four_bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .DIFF      (DIFF),
    .BOUT      (BOUT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issues one operation from IDLE (at a negedge) and checks latency and result.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ed, input logic eb, input string nm);
    int lat;
    chk({nm, "_in_ready"}, int'(in_ready), 1);
    A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = ~a; B = ~b;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, WIDTH);
    chk({nm, "_diff"}, int'(DIFF), int'(ed));
    chk({nm, "_bout"}, int'(BOUT), int'(eb));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [7:0] q [$];
  logic [7:0] item;
  logic [3:0] ea, eb4;
  int last_acc, accepts, seen, lat2;

  initial begin
    vecs[0] = '{a: 4'h9, b: 4'h3, diff: 4'h6, bout: 1'b0};
    vecs[1] = '{a: 4'h3, b: 4'h9, diff: 4'hA, bout: 1'b1};
    vecs[2] = '{a: 4'h0, b: 4'h0, diff: 4'h0, bout: 1'b0};
    vecs[3] = '{a: 4'hF, b: 4'hF, diff: 4'h0, bout: 1'b0};
    vecs[4] = '{a: 4'h0, b: 4'h1, diff: 4'hF, bout: 1'b1};
    vecs[5] = '{a: 4'hF, b: 4'h0, diff: 4'hF, bout: 1'b0};
    vecs[6] = '{a: 4'h8, b: 4'h7, diff: 4'h1, bout: 1'b0};
    vecs[7] = '{a: 4'h7, b: 4'h8, diff: 4'hF, bout: 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_diff", int'(DIFF), 0);
    chk("reset_bout", int'(BOUT), 0);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout, $sformatf("vec%0d", i));

    // Hold the result in DONE for 5 cycles while in_valid pulses.
    A = 4'hC; B = 4'h5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat2 = 0;
    while (!out_valid && lat2 < 40) begin
      @(negedge clk);
      lat2++;
    end
    chk("hold_latency", lat2, WIDTH);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      A = 4'h1; B = 4'h2;
      @(negedge clk);
      chk($sformatf("hold%0d_out_valid", i), int'(out_valid), 1);
      chk($sformatf("hold%0d_in_ready", i), int'(in_ready), 0);
      chk($sformatf("hold%0d_diff", i), int'(DIFF), 7);
      chk($sformatf("hold%0d_bout", i), int'(BOUT), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_release_out_valid", int'(out_valid), 0);
    chk("hold_release_in_ready", int'(in_ready), 1);

    // Reset two cycles into RUN aborts the operation.
    A = 4'h5; B = 4'h7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_diff", int'(DIFF), 0);
    chk("abort_bout", int'(BOUT), 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);

    // Reset wins over a simultaneous input handshake.
    A = 4'h9; B = 4'h1; in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_prio_in_ready", int'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_prio_no_result", seen, 0);

    // Continuous in_valid with out_ready always high; operands change every cycle.
    in_valid = 1'b1; out_ready = 1'b1;
    last_acc = -1; accepts = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("stream_unexpected_result", 1, 0);
        end else begin
          item = q.pop_front();
          ea = item[7:4]; eb4 = item[3:0];
          chk("stream_diff", int'(DIFF), int'(4'(ea - eb4)));
          chk("stream_bout", int'(BOUT), int'(ea < eb4));
        end
      end
      A = 4'($urandom_range(15, 0));
      B = 4'($urandom_range(15, 0));
      if (in_ready) begin
        q.push_back({A, B});
        if (last_acc >= 0) chk("stream_interval", cyc - last_acc, WIDTH + 2);
        last_acc = cyc;
        accepts++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    lat2 = 0;
    while (q.size() != 0 && lat2 < 40) begin
      if (out_valid) begin
        item = q.pop_front();
        ea = item[7:4]; eb4 = item[3:0];
        chk("drain_diff", int'(DIFF), int'(4'(ea - eb4)));
        chk("drain_bout", int'(BOUT), int'(ea < eb4));
      end
      @(negedge clk);
      lat2++;
    end
    chk("stream_drained", q.size(), 0);
    chk("stream_accepts", int'(accepts >= 12), 1);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Exhaustive sweep against the arithmetic model.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(4'(a), 4'(b), 4'(a - b), (a < b), $sformatf("sweep_%0d_%0d", a, b));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/four_bit_serial_subtractor.md
FOUR_BIT_SERIAL_SUBTRACTOR -- requirements
Module: four_bit_serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: the operand and difference width in bits, legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair on A/B is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have port A, input, WIDTH bits: the minuend, unsigned.
REQ-007 The block SHALL have port B, input, WIDTH bits: the subtrahend, unsigned.
REQ-008 The block SHALL have port out_valid, output, 1 bit: DIFF/BOUT hold a result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port DIFF, output, WIDTH bits: A minus B, modulo 2^WIDTH.
REQ-011 The block SHALL have port BOUT, output, 1 bit: the borrow out, 1 exactly when A < B.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-014 An input handshake (in_valid and in_ready high at a rising edge) SHALL capture A and B, clear the borrow register, set bit index to 0, and move to RUN.
REQ-015 In RUN, each cycle SHALL process one bit LSB-first:
- d = a xor b xor borrow;
- borrow_next = (not a and b) or (not (a xor b) and borrow);
- d is shifted into the DIFF register at bit position index.
REQ-016 After the edge that processes bit WIDTH-1, the FSM SHALL enter DONE, so out_valid rises exactly WIDTH cycles after the accepting edge.
REQ-017 In DONE, out_valid SHALL be 1 and DIFF and BOUT SHALL be held stable until an output handshake (out_valid and out_ready high at an edge); the FSM then returns to IDLE.
REQ-018 out_valid SHALL be 0 in IDLE and RUN; DIFF and BOUT SHALL keep their last result outside DONE.
REQ-019 in_valid asserted in RUN or DONE SHALL be ignored: no capture and no state change.
REQ-020 Changes on A/B after capture SHALL NOT affect the result in progress.
REQ-021 out_ready asserted outside DONE SHALL have no effect.
REQ-022 The bit index SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap inside one operation.
REQ-023 Minimum issue interval SHALL be WIDTH+2 cycles: accept, WIDTH RUN cycles, DONE, IDLE.

Reset
REQ-024 While rst is high at an edge, the block SHALL enter IDLE and clear DIFF, BOUT, the borrow register, the index and the operand registers to 0; out_valid SHALL be 0 and in_ready SHALL be 1 after that edge.
REQ-025 rst SHALL take priority over any simultaneous handshake.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL abort the operation with no result delivered.

Structure
REQ-027 A shared package SHALL hold the FSM state enumeration and the default WIDTH constant.
REQ-028 The per-bit borrow logic SHALL be a combinational sub-module full_subtractor (ports A, B, BIN, D, BOUT), instantiated once.
REQ-029 Outputs SHALL be driven directly from registers: no combinational path from any input to out_valid, DIFF or BOUT.

Verification
REQ-030 The bench SHALL apply A=9, B=3, WIDTH=4 and require out_valid exactly 4 cycles after accept with DIFF=6, BOUT=0.
REQ-031 The bench SHALL apply A=3, B=9 and require DIFF=0xA, BOUT=1; then A=0, B=0 -> DIFF=0, BOUT=0; then A=0xF, B=0xF -> DIFF=0, BOUT=0.
REQ-032 The bench SHALL hold out_ready=0 for 5 cycles in DONE and require out_valid=1 and DIFF/BOUT unchanged throughout, with in_ready=0 even while in_valid pulses.
REQ-033 The bench SHALL assert rst for 1 cycle after 2 RUN cycles of A=5, B=7 and require IDLE, in_ready=1, out_valid=0, DIFF=0 next cycle, with no result emitted.
REQ-034 The bench SHALL drive in_valid continuously with random operands and require exactly one accept per WIDTH+2 cycles, every result matching (A-B) mod 16 and BOUT matching A<B.
REQ-035 The bench SHALL sweep all 256 A/B pairs and compare DIFF/BOUT against a reference model.
